// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall/forwarding controller for a 5-stage RV32I pipeline.
// Optional macro FORWARDING_EN: enables EX operand forwarding (otherwise RAW hazards stall until WB retires).
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_write,
    input  logic                  id_load,
    input  logic                  id_store,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_en,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  wb_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [REG_ADDR_W-1:0] RD_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                  ex_write_r;
    logic                  ex_load_r;
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic                  mem_write_r;
    logic [REG_ADDR_W-1:0] mem_rd_r;
    logic                  wb_write_r;
    logic [REG_ADDR_W-1:0] wb_rd_r;
`ifdef FORWARDING_EN
    logic [REG_ADDR_W-1:0] ex_rs1_r;
    logic [REG_ADDR_W-1:0] ex_rs2_r;
`endif
    logic [CNT_W-1:0]      stall_count_r;

    logic       hazard_s;
    logic       pc_en_s;
    logic       if_id_en_s;
    logic       if_id_flush_s;
    logic       id_ex_bubble_s;
    logic       ex_mem_en_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // True when the ID instruction really reads register rd (x0 never counts).
    function automatic logic id_reads(
        input logic                  valid,
        input logic                  use1,
        input logic                  use2,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic [REG_ADDR_W-1:0] rd
    );
        id_reads = valid && (rd != RD_ZERO) &&
                   ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  m_write,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_write,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (m_write && (m_rd != RD_ZERO) && (m_rd == rs)) begin
            fwd_sel = 2'b01;
        end else if (w_write && (w_rd != RD_ZERO) && (w_rd == rs)) begin
            fwd_sel = 2'b10;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction
`endif

    // Hazard detection, forwarding selects and prioritised stage enables.
    always_comb begin
        hazard_s       = 1'b0;
        fwd_a_s        = 2'b00;
        fwd_b_s        = 2'b00;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        ex_mem_en_s    = 1'b1;
`ifdef FORWARDING_EN
        hazard_s = ex_load_r &&
                   id_reads(id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, ex_rd_r);
        fwd_a_s  = fwd_sel(ex_rs1_r, mem_write_r, mem_rd_r, wb_write_r, wb_rd_r);
        fwd_b_s  = fwd_sel(ex_rs2_r, mem_write_r, mem_rd_r, wb_write_r, wb_rd_r);
`else
        // Without forwarding, any in-flight producer blocks the reader until it retires from WB.
        hazard_s = ((ex_write_r || ex_load_r) &&
                    id_reads(id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, ex_rd_r)) ||
                   (mem_write_r &&
                    id_reads(id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, mem_rd_r)) ||
                   (wb_write_r &&
                    id_reads(id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, wb_rd_r));
`endif
        if (!mem_ready) begin
            pc_en_s     = 1'b0;
            if_id_en_s  = 1'b0;
            ex_mem_en_s = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if (hazard_s) begin
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else begin
            pc_en_s = 1'b1;
        end
    end

    // Shadow pipeline of the control word, advancing with the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_write_r  <= 1'b0;
            ex_load_r   <= 1'b0;
            ex_rd_r     <= RD_ZERO;
            mem_write_r <= 1'b0;
            mem_rd_r    <= RD_ZERO;
            wb_write_r  <= 1'b0;
            wb_rd_r     <= RD_ZERO;
`ifdef FORWARDING_EN
            ex_rs1_r    <= RD_ZERO;
            ex_rs2_r    <= RD_ZERO;
`endif
        end else if (ex_mem_en_s) begin
            wb_write_r  <= mem_write_r;
            wb_rd_r     <= mem_rd_r;
            mem_write_r <= ex_write_r;
            mem_rd_r    <= ex_rd_r;
            if (id_ex_bubble_s || !id_valid) begin
                ex_write_r <= 1'b0;
                ex_load_r  <= 1'b0;
                ex_rd_r    <= RD_ZERO;
`ifdef FORWARDING_EN
                ex_rs1_r   <= RD_ZERO;
                ex_rs2_r   <= RD_ZERO;
`endif
            end else begin
                ex_write_r <= id_write;
                // A store-flagged word is never treated as a load producer.
                ex_load_r  <= id_load && !id_store;
                ex_rd_r    <= id_rd;
`ifdef FORWARDING_EN
                ex_rs1_r   <= id_rs1;
                ex_rs2_r   <= id_rs2;
`endif
            end
        end
    end

    // Saturating count of cycles lost to stalls and bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if ((!pc_en_s || id_ex_bubble_s) && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end
    end

    assign pc_en        = pc_en_s;
    assign if_id_en     = if_id_en_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_bubble = id_ex_bubble_s;
    assign ex_mem_en    = ex_mem_en_s;
    assign fwd_a_sel    = fwd_a_s;
    assign fwd_b_sel    = fwd_b_s;
    assign wb_write     = wb_write_r;
    assign wb_rd        = wb_rd_r;
    assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Table-driven, scoreboarded bench for pipeline_hazard_controller (both FORWARDING_EN builds).
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic       load;
        logic       store;
        logic       u1;
        logic       u2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    typedef struct packed {
        ins_t        ins;
        logic        redirect;
        logic        ready;
        logic [30:0] exp;
    } vec_t;

    // Enable patterns {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en}
    localparam logic [4:0] RUN = 5'b11001;
    localparam logic [4:0] STL = 5'b00011;
    localparam logic [4:0] RED = 5'b11111;
    localparam logic [4:0] HLD = 5'b00000;
    localparam ins_t       NOP = '0;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_write, id_load, id_store, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_redirect, mem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [15:0] stall_count;

    vec_t        tbl[$];
    logic [30:0] exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] base_sc;

    pipeline_hazard_controller #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_write(id_write), .id_load(id_load), .id_store(id_store),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .wb_write(wb_write), .wb_rd(wb_rd), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t mk(input logic w, input logic l, input logic u1, input logic u2,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        ins_t r;
        r.valid = 1'b1; r.write = w; r.load = l; r.store = 1'b0;
        r.u1 = u1; r.u2 = u2; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        return r;
    endfunction

    function automatic logic [30:0] ev(input logic [4:0] e, input logic [3:0] f, input logic ww,
                                       input logic [4:0] wrd, input logic [15:0] sc);
        return {e, f, ww, wrd, sc};
    endfunction

    function automatic void add(input ins_t i, input logic red, input logic rdy, input logic [30:0] e);
        vec_t v;
        v.ins = i; v.redirect = red; v.ready = rdy; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic drive(input ins_t i, input logic red, input logic rdy);
        id_valid = i.valid; id_write = i.write; id_load = i.load; id_store = i.store;
        id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        ex_redirect = red; mem_ready = rdy;
    endtask

    task automatic check(input string name);
        logic [30:0] got, want;
        got = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en,
               fwd_a_sel, fwd_b_sel, wb_write, wb_rd, stall_count};
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s got=%h want=<none queued>", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL %s got=%h want=%h (en=%b fa=%b fb=%b wbw=%b wbrd=%0d sc=%0d)",
                         name, got, want, got[30:26], got[25:24], got[23:22],
                         got[21], got[20:16], got[15:0]);
            end
        end
    endtask

    initial begin
        ins_t lw5, a6, iv, ax0, r8, lw9, a10, ad7, r11, i12, i13, s4, ad3, a4, lw13, r14;
        lw5 = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5);
        a6  = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd1, 5'd6);
        lw9 = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd9);
        a10 = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd10);
        lw13 = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd13);
        r14 = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 5'd0, 5'd14);
`ifdef FORWARDING_EN
        s4  = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 5'd4);
        ad3 = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3);
        a4  = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd4);
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd0));
        add(lw5, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd0));
        add(a6,  1'b0, 1'b1, ev(STL, 4'b0000, 1'b0, 5'd0, 16'd0));
        add(a6,  1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd1));
        add(s4,  1'b0, 1'b1, ev(RUN, 4'b1000, 1'b1, 5'd5, 16'd1));
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0101, 1'b0, 5'd0, 16'd1));
        add(ad3, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd6, 16'd1));
        add(ad3, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd4, 16'd1));
        add(a4,  1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd1));
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0101, 1'b1, 5'd3, 16'd1));
        add(lw9, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd3, 16'd1));
        add(a10, 1'b1, 1'b1, ev(RED, 4'b0000, 1'b1, 5'd4, 16'd1));
        for (int k = 0; k < 3; k++)
            add(NOP, 1'b1, 1'b0, ev(HLD, 4'b0000, 1'b0, 5'd0, 16'(2 + k)));
        add(NOP, 1'b1, 1'b1, ev(RED, 4'b0000, 1'b0, 5'd0, 16'd5));
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd9, 16'd6));
        base_sc = 16'd6;
`else
        iv  = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0);
        iv.valid = 1'b0;
        ax0 = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        r8  = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd8);
        ad7 = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd7);
        r11 = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd11);
        i12 = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd11, 5'd12);
        i13 = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd11, 5'd13);
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd0));
        add(lw5, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd0));
        add(a6,  1'b0, 1'b1, ev(STL, 4'b0000, 1'b0, 5'd0, 16'd0));
        add(a6,  1'b0, 1'b1, ev(STL, 4'b0000, 1'b0, 5'd0, 16'd1));
        add(a6,  1'b0, 1'b1, ev(STL, 4'b0000, 1'b1, 5'd5, 16'd2));
        add(a6,  1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd3));
        add(iv,  1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd3));
        add(ax0, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd3));
        add(r8,  1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd6, 16'd3));
        add(lw9, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd3));
        add(a10, 1'b1, 1'b1, ev(RED, 4'b0000, 1'b1, 5'd0, 16'd3));
        for (int k = 0; k < 3; k++)
            add(NOP, 1'b1, 1'b0, ev(HLD, 4'b0000, 1'b1, 5'd8, 16'(4 + k)));
        add(NOP, 1'b1, 1'b1, ev(RED, 4'b0000, 1'b1, 5'd8, 16'd7));
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd9, 16'd8));
        add(ad7, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd8));
        add(r11, 1'b0, 1'b1, ev(STL, 4'b0000, 1'b0, 5'd0, 16'd8));
        add(r11, 1'b0, 1'b1, ev(STL, 4'b0000, 1'b0, 5'd0, 16'd9));
        add(r11, 1'b0, 1'b1, ev(STL, 4'b0000, 1'b1, 5'd7, 16'd10));
        add(r11, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd11));
        add(i12, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd11));
        add(i13, 1'b0, 1'b1, ev(STL, 4'b0000, 1'b0, 5'd0, 16'd11));
        add(NOP, 1'b0, 1'b1, ev(RUN, 4'b0000, 1'b1, 5'd11, 16'd12));
        base_sc = 16'd12;
`endif

        rst_n = 1'b0;
        drive(NOP, 1'b0, 1'b1);
        #12 rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].ins, tbl[k].redirect, tbl[k].ready);
            exp_q.push_back(tbl[k].exp);
            @(negedge clk);
            check($sformatf("vec%0d", k));
            @(posedge clk);
            #1;
        end

        // Load-use stall, then an asynchronous reset in the middle of it.
        drive(lw13, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(r14, 1'b0, 1'b1);
        exp_q.push_back(ev(STL, 4'b0000, 1'b0, 5'd0, base_sc));
        @(negedge clk);
        check("pre_reset_stall");
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd0));
        check("in_reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(NOP, 1'b0, 1'b1);
        exp_q.push_back(ev(RUN, 4'b0000, 1'b0, 5'd0, 16'd0));
        @(negedge clk);
        check("post_reset_fetch");

        // Long memory hold drives the stall counter into saturation.
        @(posedge clk);
        #1;
        drive(NOP, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        exp_q.push_back(ev(HLD, 4'b0000, 1'b0, 5'd0, 16'hFFFE));
        @(negedge clk);
        check("sat_near");
        @(posedge clk);
        exp_q.push_back(ev(HLD, 4'b0000, 1'b0, 5'd0, 16'hFFFF));
        @(negedge clk);
        check("sat_max");
        @(posedge clk);
        exp_q.push_back(ev(HLD, 4'b0000, 1'b0, 5'd0, 16'hFFFF));
        @(negedge clk);
        check("sat_hold");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
